// File: rtl/axi_if_pkg.sv
// -----------------------------------------------------------------------------
// axi_if_pkg
// Shared AXI4-Lite definitions for the interconnect-side blocks.
//   axi_prm_t          : port width bundle (address / read-data widths)
//   AXI_PRM_DEFAULT    : 32-bit address, 32-bit read data
//   axi_rd_arb_state_t : read arbiter FSM state (IDLE, ADDR, DATA)
// -----------------------------------------------------------------------------
package axi_if_pkg;

    typedef struct packed {
        int unsigned ADDR_WIDTH;
        int unsigned RDATA_WIDTH;
    } axi_prm_t;

    localparam axi_prm_t AXI_PRM_DEFAULT = '{ADDR_WIDTH: 32, RDATA_WIDTH: 32};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } axi_rd_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker, shared by the read and write
// arbiters. Searches req from ptr upward, wrapping N-1 -> 0.
//   req   [N]  : request bits
//   ptr   [IW] : search start index (must be < N)
//   found      : any request set
//   idx   [IW] : first requester found from ptr (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic [IW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest candidate back to ptr so the nearest
        // requester in round-robin order is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_rd_arbiter
// Round-robin arbiter sharing one AXI4-Lite read port among N requesters.
// One transaction outstanding at a time: IDLE (arbitrate + accept AR),
// ADDR (present AR to the shared port), DATA (route the single R beat).
// Ports:
//   ACLK, ARESET                      : clock, async active-high reset
//   s_arvalid/s_arready/s_araddr      : per-requester AR channel
//   s_rvalid/s_rready                 : per-requester R handshake
//   s_rdata/s_rresp                   : R payload, broadcast to all requesters
//   m_arvalid/m_arready/m_araddr      : shared AR channel (registered valid/addr)
//   m_rvalid/m_rready/m_rdata/m_rresp : shared R channel
// -----------------------------------------------------------------------------
module axi_lite_rd_arbiter
    import axi_if_pkg::*;
#(
    parameter int N          = 2,
    parameter int ADDR_WIDTH = int'(AXI_PRM_DEFAULT.ADDR_WIDTH),
    parameter int DATA_WIDTH = int'(AXI_PRM_DEFAULT.RDATA_WIDTH)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [N-1:0]            s_arvalid,
    output logic [N-1:0]            s_arready,
    input  logic [N*ADDR_WIDTH-1:0] s_araddr,
    output logic [N-1:0]            s_rvalid,
    input  logic [N-1:0]            s_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    axi_rd_arb_state_t state, state_nxt;
    logic [IW-1:0]     gnt, ptr, win;
    logic              found;
    logic [ADDR_WIDTH-1:0] req_addr [N];

    for (genvar i = 0; i < N; i++) begin : g_addr
        assign req_addr[i] = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (s_arvalid),
        .ptr   (ptr),
        .found (found),
        .idx   (win)
    );

    // R payload is a pure pass-through; only the valid/ready pair is steered.
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        case (state)
            IDLE: begin
                // Grant and accept happen in the same cycle, so a requester
                // that drops valid early simply never gets picked.
                if (found) begin
                    s_arready[win] = 1'b1;
                    state_nxt      = ADDR;
                end
            end
            ADDR: begin
                // m_rvalid here would be a protocol violation; ignored.
                if (m_arready) state_nxt = DATA;
            end
            DATA: begin
                s_rvalid[gnt] = m_rvalid;
                m_rready      = s_rready[gnt];
                if (m_rvalid && s_rready[gnt]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Keep handshakes quiet for the whole reset window, not just after
        // the state register has been cleared.
        if (ARESET) begin
            s_arready = '0;
            s_rvalid  = '0;
            m_rready  = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            gnt       <= '0;
            ptr       <= '0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    gnt       <= win;
                    m_araddr  <= req_addr[win];
                    m_arvalid <= 1'b1;
                end
                ADDR: if (m_arready) m_arvalid <= 1'b0;
                DATA: if (m_rvalid && s_rready[gnt]) begin
                    // Just-served requester becomes lowest priority.
                    ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
module tb_axi_lite_rd_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [N-1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [N*AW-1:0] s_araddr;
    logic [DW-1:0] s_rdata, m_rdata;
    logic [1:0]    s_rresp, m_rresp;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_araddr;
    logic [AW-1:0] addr [N];

    always_comb for (int i = 0; i < N; i++) s_araddr[i*AW +: AW] = addr[i];

    always #5 ACLK = ~ACLK;

    axi_lite_rd_arbiter #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit            md_busy, md_data;
    int            md_gnt, md_ptr;
    logic [AW-1:0] ar_q [$];
    int            r_q  [$];
    int            gnt_log [$];

    always @(negedge ACLK) begin
        int w, c;
        if (ARESET) begin
            md_busy = 0; md_data = 0; md_ptr = 0; md_gnt = 0;
            ar_q.delete(); r_q.delete();
            chk("rst_s_arready", 64'(s_arready), 64'(0));
            chk("rst_s_rvalid",  64'(s_rvalid),  64'(0));
            chk("rst_m_rready",  64'(m_rready),  64'(0));
            chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
            chk("rst_m_araddr",  64'(m_araddr),  64'(0));
        end else begin
            chk("r_passthru", 64'({s_rresp, s_rdata}), 64'({m_rresp, m_rdata}));
            if (!md_busy) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    c = (md_ptr + k) % N;
                    if (w < 0 && bit_of(s_arvalid, c)) w = c;
                end
                chk("idle_s_arready", 64'(s_arready), 64'((w >= 0) ? oh(w) : '0));
                chk("idle_m_arvalid", 64'(m_arvalid), 64'(0));
                chk("idle_s_rvalid",  64'(s_rvalid),  64'(0));
                chk("idle_m_rready",  64'(m_rready),  64'(0));
                if (w >= 0) begin
                    md_busy = 1; md_data = 0; md_gnt = w;
                    ar_q.push_back(addr[w]);
                end
            end else if (!md_data) begin
                chk("addr_m_arvalid", 64'(m_arvalid), 64'(1));
                chk("addr_s_arready", 64'(s_arready), 64'(0));
                chk("addr_s_rvalid",  64'(s_rvalid),  64'(0));
                chk("addr_m_rready",  64'(m_rready),  64'(0));
                if (m_arready) begin
                    md_data = 1;
                    r_q.push_back(md_gnt);
                end
            end else begin
                chk("data_s_rvalid",  64'(s_rvalid),  64'(m_rvalid ? oh(md_gnt) : '0));
                chk("data_m_rready",  64'(m_rready),  64'(bit_of(s_rready, md_gnt)));
                chk("data_s_arready", 64'(s_arready), 64'(0));
                chk("data_m_arvalid", 64'(m_arvalid), 64'(0));
                if (m_rvalid && bit_of(s_rready, md_gnt)) begin
                    md_ptr  = (md_gnt + 1) % N;
                    md_busy = 0;
                    md_data = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge ACLK) begin
        int g;
        if (!ARESET) begin
            for (int i = 0; i < N; i++) if (bit_of(s_arready, i)) gnt_log.push_back(i);
            if (m_arvalid) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 64'(m_arvalid), 64'(0));
                else begin
                    chk("m_araddr", 64'(m_araddr), 64'(ar_q[0]));
                    if (m_arready) void'(ar_q.pop_front());
                end
            end
            if ((s_rvalid & s_rready) != '0) begin
                if (r_q.size() == 0) chk("r_unexpected", 64'(s_rvalid), 64'(0));
                else begin
                    g = r_q.pop_front();
                    chk("r_route", 64'(s_rvalid), 64'(oh(g)));
                    chk("r_data",  64'({s_rresp, s_rdata}), 64'({m_rresp, m_rdata}));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] hs;

    initial begin
        ARESET = 1; s_arvalid = '0; s_rready = '0; m_arready = 0; m_rvalid = 0;
        m_rdata = '0; m_rresp = '0;
        for (int i = 0; i < N; i++) addr[i] = '0;
        repeat (3) tick();
        ARESET = 0;

        // single request from requester 0
        s_arvalid = 2'b01; addr[0] = 32'h1000; m_arready = 1;
        #1 chk("single_s_arready", 64'(s_arready), 64'(2'b01));
        tick();
        s_arvalid = '0;
        #1 chk("single_m_arvalid", 64'(m_arvalid), 64'(1));
        chk("single_m_araddr", 64'(m_araddr), 64'(32'h1000));
        tick();
        m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00; s_rready = 2'b11;
        #1 chk("single_s_rvalid", 64'(s_rvalid), 64'(2'b01));
        chk("single_s_rdata", 64'({s_rresp, s_rdata}), 64'({2'b00, 32'hDEADBEEF}));
        tick();
        m_rvalid = 0;

        // simultaneous requests from reset: 0,1,0,1
        ARESET = 1; s_arvalid = 2'b11; addr[0] = 32'hA000; addr[1] = 32'hB000;
        m_rvalid = 1; s_rready = 2'b11; m_arready = 1;
        tick(); tick();
        ARESET = 0;
        gnt_log.delete();
        repeat (12) tick();
        s_arvalid = '0; m_rvalid = 0;
        chk("rr_count", 64'(gnt_log.size()), 64'(4));
        if (gnt_log.size() == 4)
            for (int k = 0; k < 4; k++) chk("rr_order", 64'(gnt_log[k]), 64'(k % 2));

        // AR backpressure
        s_arvalid = 2'b10; addr[1] = 32'h2000; m_arready = 0;
        #1 chk("arbp_grant", 64'(s_arready), 64'(2'b10));
        tick();
        s_arvalid = 2'b01;
        repeat (5) begin
            chk("arbp_m_arvalid", 64'(m_arvalid), 64'(1));
            chk("arbp_m_araddr",  64'(m_araddr),  64'(32'h2000));
            chk("arbp_s_arready", 64'(s_arready), 64'(0));
            tick();
        end
        m_arready = 1;
        tick();

        // R backpressure on requester 1
        m_rvalid = 1; m_rdata = 32'h1234_5678; s_rready = 2'b01;
        repeat (3) begin
            #1 chk("rbp_m_rready", 64'(m_rready), 64'(0));
            chk("rbp_s_rvalid", 64'(s_rvalid), 64'(2'b10));
            tick();
        end
        s_rready = 2'b11;
        #1 chk("rbp_release", 64'(m_rready), 64'(1));
        tick();
        #1 chk("rbp_idle_grant", 64'(s_arready), 64'(2'b01));
        m_rvalid = 0;
        tick();
        s_arvalid = '0;
        tick();

        // reset while in DATA
        m_rvalid = 1; s_rready = 2'b11;
        #1 chk("prerst_s_rvalid", 64'(s_rvalid), 64'(2'b01));
        ARESET = 1; s_arvalid = 2'b11;
        #1 chk("midrst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("midrst_m_rready",  64'(m_rready),  64'(0));
        chk("midrst_s_rvalid",  64'(s_rvalid),  64'(0));
        chk("midrst_s_arready", 64'(s_arready), 64'(0));
        tick(); tick();
        ARESET = 0;
        #1 chk("postrst_grant", 64'(s_arready), 64'(2'b01));
        tick();
        s_arvalid = 2'b10;

        // randomized traffic
        repeat (3000) begin
            @(negedge ACLK);
            hs = s_arvalid & s_arready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs[i] || !s_arvalid[i]) begin
                    s_arvalid[i] = 1'($urandom_range(0, 1));
                    addr[i] = $urandom;
                end
            end
            m_arready = ($urandom_range(0, 3) != 0);
            m_rvalid  = ($urandom_range(0, 2) != 0);
            m_rdata   = $urandom;
            m_rresp   = 2'($urandom_range(0, 3));
            s_rready  = N'($urandom);
        end

        // drain
        s_arvalid = '0; m_arready = 1; m_rvalid = 1; s_rready = '1;
        repeat (10) tick();
        chk("drain_ar_q", 64'(ar_q.size()), 64'(0));
        chk("drain_r_q",  64'(r_q.size()),  64'(0));
        chk("drain_m_arvalid", 64'(m_arvalid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
